if_fetch_ctrl: RTL and testbench

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

---
 rtl/if_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// if_fetch_ctrl: single-outstanding instruction fetch controller.
//
// Accepts a next PC from the PC ALU, issues one instruction-memory request for it, waits for the
// read data and presents the fetched instruction to Issue until it is taken. A boot request
// restarts fetching from BOOT_ADDR from any state; a response that is still in flight when boot
// arrives is discarded.
//
// Parameters
//   BOOT_ADDR       PC loaded on reset and on boot_i.
//
// Ports
//   clk_i           clock, all state on the rising edge
//   rst_ni          asynchronous active-low reset
//   boot_i          single-cycle boot request
//   pc_valid_i      next-PC offer            pc_next_i      next PC value
//   pc_ready_o      next PC can be accepted
//   instr_req_o     memory request           instr_addr_o   request address
//   instr_gnt_i     memory accepted request
//   instr_rvalid_i  read data valid          instr_rdata_i  read data
//   instr_valid_o   instruction for Issue    instr_ready_i  Issue accepts it
//   instr_o         fetched instruction      instr_pc_o     PC of instr_o
//   fetch_err_o     fetch error, valid with instr_valid_o
//
// Build option
//   FETCH_ALIGN_CHECK_EN  when defined, a PC with nonzero bits [1:0] skips the memory request and
//                         is delivered as an error (instr_o = 0, fetch_err_o = 1). When undefined,
//                         instr_addr_o[1:0] is forced to 00 and fetch_err_o is tied low.
// ---------------------------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_i,
    input  logic        pc_valid_i,
    input  logic [31:0] pc_next_i,
    output logic        pc_ready_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        drop_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic        in_req;
    logic        boot_drop;

    assign in_req = (state_q == StReq);

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;
    logic misaligned;

    assign misaligned   = (pc_q[1:0] != 2'b00);
    assign instr_req_o  = in_req && !drop_q && !misaligned;
    assign instr_addr_o = in_req ? pc_q : 32'h0;
    assign fetch_err_o  = err_q;
`else
    assign instr_req_o  = in_req && !drop_q;
    assign instr_addr_o = in_req ? {pc_q[31:2], 2'b00} : 32'h0;
    assign fetch_err_o  = 1'b0;
`endif

    assign pc_ready_o    = (state_q == StIdle) && !boot_i;
    assign instr_valid_o = (state_q == StOut);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;

    // On boot, a response is still owed by memory if we were waiting for it, if a request is
    // being granted this very cycle, or if an earlier dropped response has not arrived yet.
    // A response arriving in the boot cycle itself settles the debt, so nothing is left to drop.
    assign boot_drop = ((state_q == StWait) && !instr_rvalid_i)
                     || (instr_req_o && instr_gnt_i)
                     || (drop_q && !instr_rvalid_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            pc_q       <= BOOT_ADDR;
            drop_q     <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else if (boot_i) begin
            state_q    <= StReq;
            pc_q       <= BOOT_ADDR;
            drop_q     <= boot_drop;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (pc_valid_i) begin
                        pc_q    <= pc_next_i;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (drop_q) begin
                        // Request held back until the stale response has been swallowed.
                        if (instr_rvalid_i) begin
                            drop_q <= 1'b0;
                        end
`ifdef FETCH_ALIGN_CHECK_EN
                    end else if (misaligned) begin
                        instr_q    <= 32'h0;
                        instr_pc_q <= pc_q;
                        err_q      <= 1'b1;
                        state_q    <= StOut;
`endif
                    end else if (instr_gnt_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (instr_rvalid_i) begin
                        instr_q    <= instr_rdata_i;
                        instr_pc_q <= pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
                        err_q      <= 1'b0;
`endif
                        state_q    <= StOut;
                    end
                end
                StOut: begin
                    if (instr_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: a table of single fetches, hand-written sequences for
// boot, dropped responses, misalignment and asynchronous reset, then randomized traffic compared
// against a transaction-level reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] BOOT = 32'h0000_0080;

    logic        clk_i;
    logic        rst_ni;
    logic        boot_i;
    logic        pc_valid_i;
    logic [31:0] pc_next_i;
    logic        pc_ready_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fetch_err_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    if_fetch_ctrl #(.BOOT_ADDR(BOOT)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .boot_i        (boot_i),
        .pc_valid_i    (pc_valid_i),
        .pc_next_i     (pc_next_i),
        .pc_ready_o    (pc_ready_o),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .fetch_err_o   (fetch_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        int          gnt_wait;
        int          rv_wait;
        int          rdy_wait;
        logic [31:0] data;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        boot_i         = 1'b0;
        pc_valid_i     = 1'b0;
        pc_next_i      = 32'h0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_ready_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        pc_valid_i = 1'b1;
        pc_next_i  = v.pc;
        settle();
        chk1("vec_pc_ready_idle", pc_ready_o, 1'b1);
        chk1("vec_valid_idle", instr_valid_o, 1'b0);
        tick();
        pc_valid_i = 1'b0;
        for (int i = 0; i <= v.gnt_wait; i++) begin
            instr_gnt_i = (i == v.gnt_wait);
            settle();
            chk1("vec_req_held", instr_req_o, 1'b1);
            chk("vec_addr_stable", instr_addr_o, v.exp_addr);
            chk1("vec_pc_ready_busy", pc_ready_o, 1'b0);
            tick();
        end
        instr_gnt_i = 1'b0;
        for (int i = 0; i <= v.rv_wait; i++) begin
            instr_rvalid_i = (i == v.rv_wait);
            instr_rdata_i  = (i == v.rv_wait) ? v.data : (32'hBAD0_0000 | 32'(i));
            settle();
            chk1("vec_single_req", instr_req_o, 1'b0);
            chk1("vec_valid_early", instr_valid_o, 1'b0);
            tick();
        end
        instr_rvalid_i = 1'b0;
        for (int i = 0; i <= v.rdy_wait; i++) begin
            instr_ready_i = (i == v.rdy_wait);
            settle();
            chk1("vec_valid_out", instr_valid_o, 1'b1);
            chk("vec_instr", instr_o, v.exp_instr);
            chk("vec_instr_pc", instr_pc_o, v.exp_pc);
            chk1("vec_err", fetch_err_o, 1'b0);
            chk1("vec_pc_ready_out", pc_ready_o, 1'b0);
            tick();
        end
        instr_ready_i = 1'b0;
        settle();
        chk1("vec_valid_after", instr_valid_o, 1'b0);
        chk1("vec_pc_ready_after", pc_ready_o, 1'b1);
        tick();
    endtask

    // Randomized traffic. The model tracks the transaction at the level of "is a fetch in
    // progress, has memory granted it, has its data come back, is a stale response owed".
    task automatic random_phase(input int cycles);
        logic        m_busy, m_granted, m_returned, m_drop, mem_pend;
        logic        e_req, e_valid, deliver, resp;
        logic [31:0] m_pc, m_instr, mem_data;
        int          mem_delay;
        m_busy = 1'b0; m_granted = 1'b0; m_returned = 1'b0; m_drop = 1'b0; mem_pend = 1'b0;
        m_pc = BOOT; m_instr = 32'h0; mem_data = 32'h0; mem_delay = 0;
        for (int c = 0; c < cycles; c++) begin
            boot_i        = ($urandom_range(0, 39) == 0);
            pc_valid_i    = 1'($urandom_range(0, 1));
            pc_next_i     = $urandom & 32'hFFFF_FFFC;
            instr_gnt_i   = ($urandom_range(0, 9) < 4);
            instr_ready_i = 1'($urandom_range(0, 1));
            deliver       = mem_pend && (mem_delay == 0);
            if (deliver) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_data;
            end else if (!mem_pend && !(m_granted && !m_returned) && !m_drop
                         && $urandom_range(0, 7) == 0) begin
                instr_rvalid_i = 1'b1;  // spurious response, must be ignored
                instr_rdata_i  = $urandom;
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = $urandom;
            end
            e_req   = m_busy && !m_granted && !m_drop;
            e_valid = m_busy && m_returned;
            settle();
            chk1("rnd_pc_ready", pc_ready_o, !m_busy && !boot_i);
            chk1("rnd_req", instr_req_o, e_req);
            if (e_req) chk("rnd_addr", instr_addr_o, {m_pc[31:2], 2'b00});
            chk1("rnd_valid", instr_valid_o, e_valid);
            if (e_valid) begin
                chk("rnd_instr", instr_o, m_instr);
                chk("rnd_instr_pc", instr_pc_o, m_pc);
            end
            chk1("rnd_err", fetch_err_o, 1'b0);
            // Advance the model across the coming clock edge.
            resp = instr_rvalid_i;
            if (boot_i) begin
                m_drop     = (m_busy && m_granted && !m_returned && !resp)
                           || (e_req && instr_gnt_i) || (m_drop && !resp);
                m_busy     = 1'b1;
                m_pc       = BOOT;
                m_granted  = 1'b0;
                m_returned = 1'b0;
            end else begin
                if (m_drop && resp) m_drop = 1'b0;
                else if (m_busy && m_granted && !m_returned && resp) begin
                    m_returned = 1'b1;
                    m_instr    = instr_rdata_i;
                end
                if (e_valid && instr_ready_i) m_busy = 1'b0;
                else if (!m_busy && pc_valid_i) begin
                    m_busy     = 1'b1;
                    m_pc       = pc_next_i;
                    m_granted  = 1'b0;
                    m_returned = 1'b0;
                end
                if (e_req && instr_gnt_i) m_granted = 1'b1;
            end
            if (deliver) mem_pend = 1'b0;
            else if (mem_pend) mem_delay--;
            if (e_req && instr_gnt_i) begin
                mem_pend  = 1'b1;
                mem_delay = int'($urandom_range(0, 2));
                mem_data  = $urandom;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 3, 0, 0, 32'h0000_00A1, 32'h0000_0100, 32'h0000_00A1,
                    32'h0000_0100};
        vecs[1] = '{32'h0000_0200, 0, 0, 4, 32'h1234_ABCD, 32'h0000_0200, 32'h1234_ABCD,
                    32'h0000_0200};
        vecs[2] = '{32'h0000_0000, 0, 0, 0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0013,
                    32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFC, 1, 2, 1, 32'hFFFF_0001, 32'hFFFF_FFFC, 32'hFFFF_0001,
                    32'hFFFF_FFFC};
        vecs[4] = '{32'h1234_5678, 2, 1, 2, 32'h8765_4321, 32'h1234_5678, 32'h8765_4321,
                    32'h1234_5678};

        // Reset state
        idle_inputs();
        rst_ni = 1'b0;
        #3;
        chk1("rst_pc_ready", pc_ready_o, 1'b1);
        chk1("rst_req", instr_req_o, 1'b0);
        chk("rst_addr", instr_addr_o, 32'h0);
        chk1("rst_valid", instr_valid_o, 1'b0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        chk1("rst_err", fetch_err_o, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Boot with a competing PC offer: boot wins and fetches from BOOT.
        boot_i     = 1'b1;
        pc_valid_i = 1'b1;
        pc_next_i  = 32'h0000_0400;
        settle();
        chk1("boot_pc_ready", pc_ready_o, 1'b0);
        tick();
        boot_i     = 1'b0;
        pc_valid_i = 1'b0;
        settle();
        chk1("boot_req", instr_req_o, 1'b1);
        chk("boot_addr", instr_addr_o, BOOT);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'h0050_0093;
        settle();
        chk1("boot_valid_early", instr_valid_o, 1'b0);
        tick();
        instr_rvalid_i = 1'b0;
        instr_ready_i  = 1'b1;
        settle();
        chk1("boot_valid", instr_valid_o, 1'b1);
        chk("boot_instr", instr_o, 32'h0050_0093);
        chk("boot_instr_pc", instr_pc_o, BOOT);
        tick();
        instr_ready_i = 1'b0;
        settle();
        chk1("boot_done", instr_valid_o, 1'b0);
        tick();

        // Table-driven single fetches
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Boot while waiting for data: the late response is dropped, BOOT is refetched.
        pc_valid_i = 1'b1;
        pc_next_i  = 32'h0000_0200;
        settle();
        tick();
        pc_valid_i  = 1'b0;
        instr_gnt_i = 1'b1;
        settle();
        chk1("drop_req", instr_req_o, 1'b1);
        tick();
        instr_gnt_i = 1'b0;
        boot_i      = 1'b1;
        settle();
        tick();
        boot_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            instr_gnt_i = 1'b1;
            settle();
            chk1("drop_req_held_low", instr_req_o, 1'b0);
            tick();
        end
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hDEAD_BEEF;
        settle();
        chk1("drop_req_low_rv", instr_req_o, 1'b0);
        tick();
        instr_rvalid_i = 1'b0;
        settle();
        chk1("drop_valid", instr_valid_o, 1'b0);
        chk1("drop_refetch_req", instr_req_o, 1'b1);
        chk("drop_refetch_addr", instr_addr_o, BOOT);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'h1111_1111;
        settle();
        tick();
        instr_rvalid_i = 1'b0;
        instr_ready_i  = 1'b1;
        settle();
        chk1("drop_new_valid", instr_valid_o, 1'b1);
        chk("drop_new_instr", instr_o, 32'h1111_1111);
        chk("drop_new_pc", instr_pc_o, BOOT);
        tick();
        instr_ready_i = 1'b0;

        // Misaligned PC
        pc_valid_i = 1'b1;
        pc_next_i  = 32'h0000_0102;
        settle();
        tick();
        pc_valid_i = 1'b0;
        settle();
`ifdef FETCH_ALIGN_CHECK_EN
        chk1("mis_no_req", instr_req_o, 1'b0);
        tick();
        instr_ready_i = 1'b1;
        settle();
        chk1("mis_valid", instr_valid_o, 1'b1);
        chk1("mis_err", fetch_err_o, 1'b1);
        chk("mis_instr", instr_o, 32'h0);
        chk("mis_pc", instr_pc_o, 32'h0000_0102);
        tick();
`else
        chk1("mis_req", instr_req_o, 1'b1);
        chk("mis_addr", instr_addr_o, 32'h0000_0100);
        instr_gnt_i = 1'b1;
        tick();
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'h0000_0013;
        settle();
        tick();
        instr_rvalid_i = 1'b0;
        instr_ready_i  = 1'b1;
        settle();
        chk1("mis_valid", instr_valid_o, 1'b1);
        chk1("mis_err", fetch_err_o, 1'b0);
        chk("mis_instr", instr_o, 32'h0000_0013);
        chk("mis_pc", instr_pc_o, 32'h0000_0102);
        tick();
`endif
        instr_ready_i = 1'b0;

        // Asynchronous reset in the middle of a request
        pc_valid_i = 1'b1;
        pc_next_i  = 32'h0000_0300;
        settle();
        tick();
        pc_valid_i = 1'b0;
        settle();
        chk1("arst_req_before", instr_req_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk1("arst_req", instr_req_o, 1'b0);
        chk1("arst_pc_ready", pc_ready_o, 1'b1);
        chk("arst_addr", instr_addr_o, 32'h0);
        chk1("arst_valid", instr_valid_o, 1'b0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = 32'hCAFE_F00D;
        settle();
        chk1("arst_late_pc_ready", pc_ready_o, 1'b1);
        tick();
        instr_rvalid_i = 1'b0;
        settle();
        chk1("arst_late_valid", instr_valid_o, 1'b0);
        chk1("arst_late_req", instr_req_o, 1'b0);
        chk1("arst_late_ready", pc_ready_o, 1'b1);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        random_phase(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
